prog_mem_arbiter: RTL and testbench

PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

---
 rtl/prog_mem_arbiter_pkg.sv | 6 +
 rtl/prog_mem_arbiter_if.sv | 37 +++
 rtl/prog_mem_arbiter_rr_arb2.sv | 15 +
 rtl/prog_mem_arbiter.sv | 72 +++++++
 tb/tb_prog_mem_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_arbiter_pkg.sv
// prog_mem_arbiter_pkg: shared widths and owner encoding for the program-memory arbiter
package prog_mem_arbiter_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 12;
    typedef enum logic {OWN_CPU = 1'b0, OWN_HOST = 1'b1} owner_e;
endpackage

// File: rtl/prog_mem_arbiter_if.sv
// prog_mem_arbiter_if: CPU, host loader and memory port signals of the arbiter
interface prog_mem_arbiter_if #(
    parameter int ADDR_W = prog_mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = prog_mem_arbiter_pkg::DATA_W
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_lock;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, host_req, host_we, host_addr, host_wdata, host_lock, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_addr, host_req, host_we, host_addr, host_wdata, host_lock, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant (bit 0 = CPU, bit 1 = host) with host lock
module rr_arb2
    import prog_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lock,
    input  owner_e     last,
    output logic [1:0] gnt
);
    // a tie goes to whoever did not own the port last; lock shuts the CPU out entirely
    always_comb begin
        gnt[0] = req[0] & ~lock & (~req[1] | (last == OWN_HOST));
        gnt[1] = req[1] & (lock | ~req[0] | (last == OWN_CPU));
    end
endmodule

// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: shares one program-memory port between CPU fetches and the host loader
module prog_mem_arbiter #(
    parameter int ADDR_W = prog_mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = prog_mem_arbiter_pkg::DATA_W
) (
    input logic               clk,
    input logic               CLB,
    prog_mem_arbiter_if.slave bus
);
    import prog_mem_arbiter_pkg::*;

    logic [1:0]        req, gnt;
    owner_e            last_owner_q, last_owner_d, tag_q, tag_d;
    logic              rd_q, rd_d, cpu_rv, host_rv;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;

    assign req = {bus.host_req, bus.cpu_req} & {2{CLB}};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .lock (bus.host_lock),
        .last (last_owner_q),
        .gnt  (gnt)
    );

    // drive the memory port from the winner, track the pending read and steer returning data
    always_comb begin
        addr_d       = gnt[0] ? bus.cpu_addr : gnt[1] ? bus.host_addr : addr_q;
        wdata_d      = gnt[1] ? bus.host_wdata : wdata_q;
        last_owner_d = gnt[0] ? OWN_CPU : gnt[1] ? OWN_HOST : last_owner_q;
        tag_d        = gnt[1] ? OWN_HOST : OWN_CPU;
        rd_d         = gnt[0] | (gnt[1] & ~bus.host_we);
        cpu_rv       = CLB & rd_q & (tag_q == OWN_CPU);
        host_rv      = CLB & rd_q & (tag_q == OWN_HOST);
        cpu_rdata_d  = cpu_rv ? bus.mem_rdata : cpu_rdata_q;
        host_rdata_d = host_rv ? bus.mem_rdata : host_rdata_q;
        bus.cpu_gnt     = gnt[0];
        bus.host_gnt    = gnt[1];
        bus.cpu_hold    = bus.cpu_req & ~gnt[0];
        bus.mem_en      = |gnt;
        bus.mem_we      = gnt[1] & bus.host_we;
        bus.mem_addr    = addr_d;
        bus.mem_wdata   = wdata_d;
        bus.cpu_rvalid  = cpu_rv;
        bus.host_rvalid = host_rv;
        bus.cpu_rdata   = cpu_rdata_d;
        bus.host_rdata  = host_rdata_d;
    end

    // arbitration history, read owner tag and held port/data values
    always_ff @(posedge clk) begin
        if (!CLB) begin
            last_owner_q <= OWN_HOST;
            tag_q        <= OWN_CPU;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            tag_q        <= tag_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb_prog_mem_arbiter: directed checks of arbitration, read return, lock and reset behaviour
module tb_prog_mem_arbiter;
    logic clk = 1'b0;
    logic CLB;
    int n_assert = 0;
    int n_fail = 0;
    int n_cpu, n_host;

    logic [11:0]  mem [256];
    logic [255:0] wr = '0;
    logic [11:0]  rdq = '0;

    prog_mem_arbiter_if bus ();

    prog_mem_arbiter dut (
        .clk (clk),
        .CLB (CLB),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory with one-cycle read latency; unwritten words read back as {4'h8, address}
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr[bus.mem_addr]  <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_we)
            rdq <= wr[bus.mem_addr] ? mem[bus.mem_addr] : {4'h8, bus.mem_addr};
    end
    assign bus.mem_rdata = rdq;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        CLB = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // requests during reset must be ignored
        bus.cpu_req = 1'b1; bus.host_req = 1'b1; bus.cpu_addr = 8'h10; bus.host_addr = 8'h20;
        #4;
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_host_gnt", bus.host_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_cpu_hold", bus.cpu_hold, 1);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_host_rvalid", bus.host_rvalid, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_host_rdata", bus.host_rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        nxt();
        // reset release with both requesting: CPU wins the first tie
        CLB = 1'b1;
        #4;
        chk("a0_cpu_gnt", bus.cpu_gnt, 1);
        chk("a0_host_gnt", bus.host_gnt, 0);
        chk("a0_mem_addr", bus.mem_addr, 8'h10);
        chk("a0_mem_we", bus.mem_we, 0);
        chk("a0_cpu_hold", bus.cpu_hold, 0);
        nxt();
        bus.cpu_req = 1'b0;
        #4;
        chk("a1_host_gnt", bus.host_gnt, 1);
        chk("a1_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("a1_cpu_rdata", bus.cpu_rdata, 12'h810);
        chk("a1_mem_addr", bus.mem_addr, 8'h20);
        nxt();
        bus.host_req = 1'b0;
        #4;
        chk("a2_host_rvalid", bus.host_rvalid, 1);
        chk("a2_host_rdata", bus.host_rdata, 12'h820);
        chk("a2_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("a2_cpu_rdata_hold", bus.cpu_rdata, 12'h810);
        chk("a2_mem_en", bus.mem_en, 0);
        chk("a2_mem_addr_hold", bus.mem_addr, 8'h20);
        nxt();
        // host write then CPU read-back
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h03; bus.host_wdata = 12'hA5C;
        #4;
        chk("b0_host_gnt", bus.host_gnt, 1);
        chk("b0_mem_we", bus.mem_we, 1);
        chk("b0_mem_addr", bus.mem_addr, 8'h03);
        chk("b0_mem_wdata", bus.mem_wdata, 12'hA5C);
        chk("b0_host_rvalid", bus.host_rvalid, 0);
        nxt();
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h03;
        #4;
        chk("b1_cpu_gnt", bus.cpu_gnt, 1);
        chk("b1_mem_we", bus.mem_we, 0);
        chk("b1_host_rvalid", bus.host_rvalid, 0);
        nxt();
        bus.cpu_req = 1'b0;
        #4;
        chk("b2_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("b2_cpu_rdata", bus.cpu_rdata, 12'hA5C);
        chk("b2_host_rdata_hold", bus.host_rdata, 12'h820);
        chk("b2_mem_wdata_hold", bus.mem_wdata, 12'hA5C);
        nxt();
        // continuous contention: last owner was CPU, so HOST first, then strict alternation
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h30;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h40;
        n_cpu = 0; n_host = 0;
        for (int i = 0; i < 8; i++) begin
            #4;
            n_cpu += int'(bus.cpu_gnt);
            n_host += int'(bus.host_gnt);
            chk($sformatf("c%0d_cpu_gnt", i), bus.cpu_gnt, (i % 2 == 1));
            chk($sformatf("c%0d_host_gnt", i), bus.host_gnt, (i % 2 == 0));
            chk($sformatf("c%0d_cpu_hold", i), bus.cpu_hold, (i % 2 == 0));
            chk($sformatf("c%0d_cpu_rvalid", i), bus.cpu_rvalid, (i > 0 && i % 2 == 0));
            chk($sformatf("c%0d_host_rvalid", i), bus.host_rvalid, (i % 2 == 1));
            nxt();
        end
        chk("c_cpu_grants", n_cpu, 4);
        chk("c_host_grants", n_host, 4);
        // host lock shuts the CPU out; host still granted while locked
        bus.host_lock = 1'b1; bus.cpu_addr = 8'h50; bus.host_addr = 8'h60;
        for (int i = 0; i < 5; i++) begin
            bus.host_req = (i == 2 || i == 3);
            #4;
            chk($sformatf("d%0d_cpu_gnt", i), bus.cpu_gnt, 0);
            chk($sformatf("d%0d_cpu_hold", i), bus.cpu_hold, 1);
            chk($sformatf("d%0d_host_gnt", i), bus.host_gnt, (i == 2 || i == 3));
            if (i == 3) begin
                chk("d3_host_rvalid", bus.host_rvalid, 1);
                chk("d3_host_rdata", bus.host_rdata, 12'h860);
            end
            nxt();
        end
        bus.host_lock = 1'b0; bus.host_req = 1'b0;
        #4;
        chk("d5_cpu_gnt", bus.cpu_gnt, 1);
        chk("d5_mem_addr", bus.mem_addr, 8'h50);
        chk("d5_host_rvalid", bus.host_rvalid, 0);
        nxt();
        // lock rising with a CPU read in flight still returns the data
        bus.cpu_req = 1'b0; bus.host_lock = 1'b1;
        #4;
        chk("e_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("e_cpu_rdata", bus.cpu_rdata, 12'h850);
        nxt();
        bus.host_lock = 1'b0;
        // reset right after a CPU read grant kills the pending rvalid
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h70;
        #4;
        chk("f0_cpu_gnt", bus.cpu_gnt, 1);
        nxt();
        bus.cpu_req = 1'b0; CLB = 1'b0;
        #4;
        chk("f1_cpu_rvalid", bus.cpu_rvalid, 0);
        nxt();
        #4;
        chk("f2_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("f2_host_rvalid", bus.host_rvalid, 0);
        chk("f2_cpu_rdata", bus.cpu_rdata, 0);
        chk("f2_host_rdata", bus.host_rdata, 0);
        chk("f2_mem_addr", bus.mem_addr, 0);
        chk("f2_mem_wdata", bus.mem_wdata, 0);
        chk("f2_mem_en", bus.mem_en, 0);
        nxt();
        CLB = 1'b1;
        #4;
        chk("f3_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("f3_mem_en", bus.mem_en, 0);
        nxt();
        // host read at the top address
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'hFF;
        #4;
        chk("g0_host_gnt", bus.host_gnt, 1);
        chk("g0_mem_addr", bus.mem_addr, 8'hFF);
        nxt();
        bus.host_req = 1'b0;
        #4;
        chk("g1_host_rvalid", bus.host_rvalid, 1);
        chk("g1_host_rdata", bus.host_rdata, 12'h8FF);
        chk("g1_cpu_rvalid", bus.cpu_rvalid, 0);
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
